// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared RV32I definitions: format codes, opcode constants, the canonical NOP
// and the field bundle captured by the encoder's first stage.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// Field-input and instruction-output handshake bundle of the RV32I encoder.
// Valid/ready: a word moves on a rising edge where valid && ready; the sender
// holds valid and payload stable until that edge, and ready never depends on valid.
interface rv32i_instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

endinterface

// File: rtl/rv32i_instr_encoder_imm_pack.sv
// Combinational RV32I packer: places fields and immediate bits exactly where
// the core's immediate extractor reads them, and flags out-of-range immediates.
module rv32i_imm_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic [31:0] word;
  logic        legal;
  logic        same_31_11;
  logic        same_31_12;
  logic        same_31_20;

  // Sign-extension checks: the dropped high bits must all equal the kept sign bit.
  assign same_31_11 = (&imm_i[31:11]) || !(|imm_i[31:11]);
  assign same_31_12 = (&imm_i[31:12]) || !(|imm_i[31:12]);
  assign same_31_20 = (&imm_i[31:20]) || !(|imm_i[31:20]);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt_i)
      FMT_R: begin
        word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal = 1'b1;
      end
      FMT_I: begin
        word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal = same_31_11;
      end
      FMT_S: begin
        word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal = same_31_11;
      end
      FMT_B: begin
        word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                 imm_i[4:1], imm_i[11], opcode_i};
        legal = same_31_12 && !imm_i[0];
      end
      FMT_U: begin
        word  = {imm_i[31:12], rd_i, opcode_i};
        legal = !(|imm_i[11:0]);
      end
      FMT_J: begin
        word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        legal = same_31_20 && !imm_i[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
    instr_o = legal ? word : NOP;
    err_o   = !legal;
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Two-stage handshaked RV32I encoder: S1 captures fields and packs them, S2 is
// the output register; rejected words leave as NOP and bump a saturating counter.
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32i_instr_encoder_if.slave bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  enc_fields_t          s1_q;
  enc_fields_t          s1_d;
  logic                 s1_valid_q;
  logic                 s1_valid_d;
  logic                 out_valid_q;
  logic                 out_valid_d;
  logic [31:0]          out_instr_q;
  logic [31:0]          out_instr_d;
  logic                 out_err_q;
  logic                 out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 s2_adv;
  logic                 s1_adv;
  logic [31:0]          pack_instr;
  logic                 pack_err;

  rv32i_imm_pack u_pack (
    .fmt_i    (s1_q.fmt),
    .opcode_i (s1_q.opcode),
    .rd_i     (s1_q.rd),
    .rs1_i    (s1_q.rs1),
    .rs2_i    (s1_q.rs2),
    .funct3_i (s1_q.funct3),
    .funct7_i (s1_q.funct7),
    .imm_i    (s1_q.imm),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  always_comb begin
    s2_adv      = !out_valid_q || bus.out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.fmt    = bus.in_fmt;
        s1_d.opcode = bus.in_opcode;
        s1_d.rd     = bus.in_rd;
        s1_d.rs1    = bus.in_rs1;
        s1_d.rs2    = bus.in_rs2;
        s1_d.funct3 = bus.in_funct3;
        s1_d.funct7 = bus.in_funct7;
        s1_d.imm    = bus.in_imm;
      end
    end

    // Output payload only changes when S2 advances, which keeps it stable under backpressure.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = pack_instr;
        out_err_d   = pack_err;
      end
    end

    if (out_valid_q && bus.out_ready && out_err_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign err_count     = err_cnt_q;

endmodule
